stream_bcast_fifo: RTL and testbench
====================================

# stream_bcast_fifo

Parametrised AXI-Stream broadcast stage. It replicates each of `N_IN` input streams onto `FANOUT` output streams. Each output has its own elastic FIFO, so one slow consumer does not stall its sibling outputs until that consumer's FIFO fills. The block sits between page-level operator streams in the partial-reconfiguration overlay, wherever one producer feeds several consumers. Backpressure is correct for every destination, and a runtime mask can disconnect individual destinations.

## Interface
Parameters:
- `DATA_W`, 32, width of one stream beat.
- `N_IN`, 2, number of input streams.
- `FANOUT`, 2, outputs per input. Output lane `j = i*FANOUT + k` carries input `i`.
- `DEPTH`, 4, entries per output FIFO. Must be a power of 2 and ≥ 2.

Ports (clock and reset first):
- `ap_clk`  in  1  sole clock. All logic is rising-edge.
- `ap_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `fanout_mask`  in  `N_IN*FANOUT`  bit `j` = 1 enables output lane `j`. Sampled every cycle.
- `in_tdata`  in  `N_IN*DATA_W`  input `i` occupies bits `[i*DATA_W +: DATA_W]`.
- `in_tvalid`  in  `N_IN`  per-input valid.
- `in_tready`  out  `N_IN`  per-input ready.
- `out_tdata`  out  `N_IN*FANOUT*DATA_W`  lane `j` occupies bits `[j*DATA_W +: DATA_W]`.
- `out_tvalid`  out  `N_IN*FANOUT`  per-lane valid.
- `out_tready`  in  `N_IN*FANOUT`  per-lane ready.
- `ap_idle`  out  1  high when all FIFOs are empty and no `in_tvalid` is asserted.

## Operation
- Each lane `j` has a FIFO with `DEPTH` entries, read/write pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`, and a count of log2(`DEPTH`)+1 bits.
- Flags:
  - `full[j]` = (count == `DEPTH`).
  - `empty[j]` = (count == 0).
- Ready:
  - `in_tready[i]` = AND over k of (`!fanout_mask[i*FANOUT+k]` | `!full[i*FANOUT+k]`).
  - `in_tready` is combinational and uses only current full flags. A pop in the same cycle does not free space.
- Accept:
  - A beat on input `i` is accepted when `in_tvalid[i] & in_tready[i]`.
  - An accepted beat is written to every enabled lane of group `i` in the same cycle.
  - Disabled lanes receive nothing.
- All lanes of group `i` disabled:
  - `in_tready[i]` = 1.
  - Accepted beats are discarded (sink mode).
- Output side:
  - `out_tvalid[j]` = `!empty[j]`.
  - `out_tdata` lane `j` = FIFO head. Head is first-word-fall-through, driven from storage with no extra register.
  - A pop occurs when `out_tvalid[j] & out_tready[j]`.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, and both pointers advance.
  - No push is possible when full, so the count never exceeds `DEPTH` and never underflows.
- Mask changes affect only future pushes. Data already buffered in a newly disabled lane still drains normally.
- Data is passed bit-exact. There is no arithmetic on the payload.
- Reset while `ap_rst_n` is low:
  - All pointers and counts clear to 0.
  - `out_tvalid` = 0 and `in_tready` = 0 (forced).
  - `ap_idle` = 1.
  - Buffered data is lost. FIFO storage itself is not reset, so `out_tdata` is don't-care while `out_tvalid` = 0.
- Reset asserted mid-burst: all state clears immediately, asynchronously. Operation resumes on the first rising edge after deassertion.

## Timing
- Latency: a beat accepted at edge N appears with `out_tvalid` high after edge N, i.e. it is consumable at edge N+1. One cycle minimum.
- Throughput: one beat per cycle per input while all enabled lanes keep up. Steady push+pop keeps the count constant.
- Backpressure:
  - Input `i` stalls exactly when any enabled lane in its group is full.
  - A lane whose `out_tready` stays low lets its group accept at most `DEPTH` further beats.
  - Other groups are unaffected.
- AXI-Stream rules:
  - `out_tvalid`/`out_tdata` stay stable until accepted.
  - `in_tready` may toggle independently of `in_tvalid`.
  - There is no combinational path from `out_tready` to `in_tready`.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on input 0 with all `out_tready` high → lanes 0 and 1 each emit 0x11, 0x22, 0x33. Lane 0 valid 1 cycle after accept. Lanes 2 and 3 stay idle.
- Hold lane 1 `out_tready` low and push 6 beats (`DEPTH`=4) on input 0 → 4 beats accepted, then `in_tready[0]`=0. Input 1 traffic continues unaffected. Releasing lane 1 drains 4 beats in order, and input 0 resumes.
- Set `fanout_mask`=4'b1101 (lane 1 off), hold lane 1 ready low, stream 10 beats → no stall. Lane 0 receives all 10 and lane 1 receives none.
- Set mask group 0 = 2'b00 → `in_tready[0]`=1 constantly. Beats are discarded, no `out_tvalid` on lanes 0/1, and `ap_idle` is unaffected by the dropped beats.
- FIFO at count 2 with simultaneous push and pop every cycle for 20 cycles → count stays 2, ordering is preserved, pointers wrap correctly.
- Assert `ap_rst_n` low mid-burst with lanes partially full → `out_tvalid`=0 and `in_tready`=0 immediately. After release, `ap_idle`=1 and the first new beat emerges with no stale data.

Source files
------------

// File: rtl/stream_bcast_fifo_if.sv
// Stream bundle for stream_bcast_fifo: N_IN producer streams in, N_IN*FANOUT lanes out.
// "slave" is the broadcast block's view; "master" is the surrounding producer/consumer view.
interface stream_bcast_fifo_if #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 2,
    parameter int FANOUT = 2
);
    localparam int N_OUT = N_IN * FANOUT;

    logic [N_IN*DATA_W-1:0]  in_tdata;
    logic [N_IN-1:0]         in_tvalid;
    logic [N_IN-1:0]         in_tready;
    logic [N_OUT*DATA_W-1:0] out_tdata;
    logic [N_OUT-1:0]        out_tvalid;
    logic [N_OUT-1:0]        out_tready;

    modport slave (
        input  in_tdata, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tvalid
    );

    modport master (
        output in_tdata, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tvalid
    );
endinterface

// File: rtl/stream_bcast_fifo.sv
// Per-lane elastic FIFO, first-word-fall-through head straight from storage.
// Latency: write at edge N is visible on rd_dat/rd_vld after edge N.
// Backpressure: caller must not push while full; full reflects registered count only.
module stream_bcast_lane_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign full   = (cnt == FULL_CNT);
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld & ~full;
    assign pop    = rd_vld & rd_rdy;

    // Storage is deliberately left out of reset; rd_vld masks stale words.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Broadcast each input stream onto FANOUT masked lanes, each with its own FIFO.
// Latency: beat accepted at edge N is valid on its lanes after edge N (one cycle).
// Backpressure: input stalls only while an enabled lane of its group is full; no out_tready->in_tready path.
module stream_bcast_fifo #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 2,
    parameter int FANOUT = 2,
    parameter int DEPTH  = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [N_IN*FANOUT-1:0] fanout_mask,
    stream_bcast_fifo_if.slave     bus,
    output logic                   ap_idle
);
    localparam int N_OUT = N_IN * FANOUT;

    logic [N_IN-1:0]   grp_rdy;
    logic [N_IN-1:0]   in_acc;
    logic [N_OUT-1:0]  lane_push;
    logic [N_OUT-1:0]  lane_block;
    logic [N_OUT-1:0]  out_vld;
    logic [N_OUT*DATA_W-1:0] out_dat;

    logic              lane_full [N_OUT];
    logic              lane_vld  [N_OUT];
    logic [DATA_W-1:0] lane_dat  [N_OUT];

    assign in_acc = bus.in_tvalid & grp_rdy;

    always_comb begin
        lane_block = '0;
        lane_push  = '0;
        out_vld    = '0;
        out_dat    = '0;
        for (int j = 0; j < N_OUT; j++) begin
            lane_block[j]              = fanout_mask[j] & lane_full[j];
            lane_push[j]               = fanout_mask[j] & in_acc[j / FANOUT];
            out_vld[j]                 = lane_vld[j];
            out_dat[j*DATA_W +: DATA_W] = lane_dat[j];
        end
    end

    // A group with every lane masked off keeps ready high and sinks its beats.
    always_comb begin
        grp_rdy = '0;
        for (int i = 0; i < N_IN; i++) begin
            grp_rdy[i] = ap_rst_n & ~|lane_block[i*FANOUT +: FANOUT];
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        stream_bcast_lane_fifo #(
            .W     (DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (ap_clk),
            .rst_n  (ap_rst_n),
            .wr_vld (lane_push[j]),
            .wr_dat (bus.in_tdata[(j / FANOUT)*DATA_W +: DATA_W]),
            .full   (lane_full[j]),
            .rd_vld (lane_vld[j]),
            .rd_dat (lane_dat[j]),
            .rd_rdy (bus.out_tready[j])
        );
    end

    assign bus.in_tready  = grp_rdy;
    assign bus.out_tvalid = out_vld;
    assign bus.out_tdata  = out_dat;
    assign ap_idle        = ~ap_rst_n | (~|out_vld & ~|bus.in_tvalid);
endmodule

// File: tb/tb_stream_bcast_fifo.sv
// Directed bench for stream_bcast_fifo: queue-per-lane model checked every cycle, plus literal checks.
module tb_stream_bcast_fifo;
    localparam int DW    = 32;
    localparam int NI    = 2;
    localparam int FO    = 2;
    localparam int NO    = NI * FO;
    localparam int DEPTH = 4;

    typedef logic [DW-1:0] q32_t [$];

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [NO-1:0] fanout_mask;
    logic          ap_idle;

    stream_bcast_fifo_if #(.DATA_W(DW), .N_IN(NI), .FANOUT(FO)) bus ();

    stream_bcast_fifo #(.DATA_W(DW), .N_IN(NI), .FANOUT(FO), .DEPTH(DEPTH)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .fanout_mask (fanout_mask),
        .bus         (bus),
        .ap_idle     (ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    int   errors = 0;
    int   checks = 0;
    q32_t src [NI];
    q32_t mq  [NO];
    q32_t rx  [NO];
    int   acc_cnt [NI];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rx(input string nm, input int lane, input q32_t e);
        chk({nm, "_len"}, DW'(rx[lane].size()), DW'(e.size()));
        for (int i = 0; i < e.size() && i < rx[lane].size(); i++)
            chk(nm, rx[lane][i], e[i]);
    endtask

    function automatic q32_t seq(input logic [DW-1:0] base, input int n);
        q32_t q;
        for (int i = 0; i < n; i++) q.push_back(base + DW'(i));
        return q;
    endfunction

    task automatic clear_logs();
        for (int j = 0; j < NO; j++) rx[j].delete();
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((src[0].size() != 0 || src[1].size() != 0 || bus.out_tvalid != '0) && n < 300) begin
            @(posedge ap_clk); #2;
            n++;
        end
        chk({nm, "_drain_timeout"}, DW'(n < 300), 1);
        @(posedge ap_clk); #2;
    endtask

    // Input driver: present the head of src[i]; retire it once a handshake was seen.
    initial begin
        logic [NI-1:0] acc;
        bus.in_tvalid = '0;
        bus.in_tdata  = '0;
        forever begin
            @(negedge ap_clk);
            acc = bus.in_tvalid & bus.in_tready;
            @(posedge ap_clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (acc[i] && src[i].size() != 0) begin
                    void'(src[i].pop_front());
                    acc_cnt[i]++;
                end
                if (src[i].size() != 0) begin
                    bus.in_tvalid[i]          = 1'b1;
                    bus.in_tdata[i*DW +: DW]  = src[i][0];
                end else begin
                    bus.in_tvalid[i] = 1'b0;
                end
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        logic [NI-1:0]    exp_rdy;
        logic [NO-1:0]    exp_vld;
        logic [NO-1:0]    pop;
        logic [NO-1:0]    msk;
        logic [NI-1:0]    acc;
        logic [NI*DW-1:0] din;
        logic             exp_idle;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                for (int j = 0; j < NO; j++) mq[j].delete();
                chk("rst_in_tready", DW'(bus.in_tready), 0);
                chk("rst_out_tvalid", DW'(bus.out_tvalid), 0);
                chk("rst_ap_idle", DW'(ap_idle), 1);
                continue;
            end
            exp_idle = (bus.in_tvalid == '0);
            for (int i = 0; i < NI; i++) begin
                exp_rdy[i] = 1'b1;
                for (int k = 0; k < FO; k++)
                    if (fanout_mask[i*FO+k] && mq[i*FO+k].size() >= DEPTH) exp_rdy[i] = 1'b0;
            end
            for (int j = 0; j < NO; j++) begin
                exp_vld[j] = (mq[j].size() != 0);
                if (exp_vld[j]) exp_idle = 1'b0;
            end
            chk("in_tready", DW'(bus.in_tready), DW'(exp_rdy));
            chk("out_tvalid", DW'(bus.out_tvalid), DW'(exp_vld));
            chk("ap_idle", DW'(ap_idle), DW'(exp_idle));
            for (int j = 0; j < NO; j++)
                if (exp_vld[j]) chk($sformatf("out_tdata%0d", j), bus.out_tdata[j*DW +: DW], mq[j][0]);
            acc = bus.in_tvalid & exp_rdy;
            pop = exp_vld & bus.out_tready;
            msk = fanout_mask;
            din = bus.in_tdata;
            for (int j = 0; j < NO; j++)
                if (pop[j]) rx[j].push_back(bus.out_tdata[j*DW +: DW]);
            @(posedge ap_clk);
            if (ap_rst_n) begin
                for (int j = 0; j < NO; j++) begin
                    if (pop[j]) void'(mq[j].pop_front());
                    if (msk[j] && acc[j / FO]) mq[j].push_back(din[(j / FO)*DW +: DW]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        q32_t e;
        ap_rst_n       = 1'b0;
        fanout_mask    = 4'hF;
        bus.out_tready = '0;
        clear_logs();
        #2;
        chk("init_in_tready", DW'(bus.in_tready), 0);
        chk("init_out_tvalid", DW'(bus.out_tvalid), 0);
        chk("init_ap_idle", DW'(ap_idle), 1);
        repeat (3) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
        @(posedge ap_clk); #2;

        // Basic broadcast, one-cycle latency.
        bus.out_tready = 4'hF;
        src[0] = '{32'h11, 32'h22, 32'h33};
        @(posedge ap_clk); #2;
        chk("t1_not_yet_valid", DW'(bus.out_tvalid), 0);
        chk("t1_busy", DW'(ap_idle), 0);
        @(posedge ap_clk); #2;
        chk("t1_lat_vld", DW'(bus.out_tvalid), 4'b0011);
        chk("t1_lat_dat", bus.out_tdata[0 +: DW], 32'h11);
        wait_drain("t1");
        e = '{32'h11, 32'h22, 32'h33};
        chk_rx("t1_lane0", 0, e);
        chk_rx("t1_lane1", 1, e);
        e = {};
        chk_rx("t1_lane2", 2, e);
        chk_rx("t1_lane3", 3, e);

        // Lane 1 blocked: group 0 takes DEPTH beats then stalls; group 1 unaffected.
        clear_logs();
        bus.out_tready = 4'b1101;
        src[0] = seq(32'hA0, 6);
        src[1] = seq(32'hB0, 4);
        repeat (12) @(posedge ap_clk); #2;
        chk("t2_acc0", DW'(acc_cnt[0]), 4);
        chk("t2_stall", DW'(bus.in_tready[0]), 0);
        chk("t2_acc1", DW'(acc_cnt[1]), 4);
        chk_rx("t2_lane0", 0, seq(32'hA0, 4));
        chk_rx("t2_lane2", 2, seq(32'hB0, 4));
        chk_rx("t2_lane3", 3, seq(32'hB0, 4));
        bus.out_tready = 4'hF;
        wait_drain("t2");
        chk("t2_acc0_end", DW'(acc_cnt[0]), 6);
        chk_rx("t2_lane1", 1, seq(32'hA0, 6));
        chk_rx("t2_lane0_end", 0, seq(32'hA0, 6));

        // Lane 1 masked off: no stall, lane 1 gets nothing.
        clear_logs();
        fanout_mask    = 4'b1101;
        bus.out_tready = 4'b1101;
        src[0] = seq(32'h100, 10);
        repeat (12) @(posedge ap_clk); #2;
        chk("t3_acc0", DW'(acc_cnt[0]), 10);
        wait_drain("t3");
        chk_rx("t3_lane0", 0, seq(32'h100, 10));
        e = {};
        chk_rx("t3_lane1", 1, e);

        // Group 0 fully masked: sink mode.
        clear_logs();
        fanout_mask    = 4'b1100;
        bus.out_tready = 4'hF;
        src[0] = seq(32'h200, 5);
        repeat (8) @(posedge ap_clk); #2;
        chk("t4_acc0", DW'(acc_cnt[0]), 5);
        chk("t4_rdy", DW'(bus.in_tready[0]), 1);
        chk("t4_idle", DW'(ap_idle), 1);
        e = {};
        chk_rx("t4_lane0", 0, e);
        chk_rx("t4_lane1", 1, e);

        // Lane 0 held at count 2 with push+pop every cycle for 20 cycles.
        clear_logs();
        fanout_mask    = 4'hF;
        bus.out_tready = 4'b1110;
        src[0] = '{32'h0F0, 32'h0F1};
        repeat (4) @(posedge ap_clk); #2;
        src[0] = seq(32'hC00, 20);
        @(posedge ap_clk); #2;
        bus.out_tready[0] = 1'b1;
        repeat (20) @(posedge ap_clk); #2;
        bus.out_tready[0] = 1'b0;
        e = '{32'h0F0, 32'h0F1};
        for (int k = 0; k < 18; k++) e.push_back(32'hC00 + DW'(k));
        chk_rx("t5_lane0_mid", 0, e);
        chk("t5_head_vld", DW'(bus.out_tvalid[0]), 1);
        chk("t5_head_dat", bus.out_tdata[0 +: DW], 32'hC12);
        bus.out_tready = 4'hF;
        wait_drain("t5");
        e.push_back(32'hC12);
        e.push_back(32'hC13);
        chk_rx("t5_lane0", 0, e);
        chk_rx("t5_lane1", 1, e);

        // Reset mid-burst with lanes partially full.
        clear_logs();
        bus.out_tready = '0;
        src[0] = '{32'h61, 32'h62, 32'h63};
        src[1] = '{32'h71, 32'h72};
        repeat (3) @(posedge ap_clk); #2;
        chk("t6_prefill", DW'(bus.out_tvalid), 4'hF);
        ap_rst_n = 1'b0;
        src[0].delete();
        src[1].delete();
        #1;
        chk("t6_rst_vld", DW'(bus.out_tvalid), 0);
        chk("t6_rst_rdy", DW'(bus.in_tready), 0);
        chk("t6_rst_idle", DW'(ap_idle), 1);
        repeat (2) @(posedge ap_clk); #2;
        ap_rst_n = 1'b1;
        clear_logs();
        @(negedge ap_clk);
        chk("t6_post_idle", DW'(ap_idle), 1);
        chk("t6_post_vld", DW'(bus.out_tvalid), 0);
        @(posedge ap_clk); #2;
        bus.out_tready = 4'hF;
        src[0] = '{32'hD1};
        wait_drain("t6");
        e = '{32'hD1};
        chk_rx("t6_lane0", 0, e);
        chk_rx("t6_lane1", 1, e);
        e = {};
        chk_rx("t6_lane2", 2, e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
